rtc_time_writer: RTL and testbench

- Downstream of the time-edit stage: takes the edited BCD time (HC/MC/SC, AmPm, format) on a commit pulse and writes it into the external RTC's time registers.
- Validates the BCD values and encodes the hour register for 12 h or 24 h mode.
- Issues seconds, minutes, hours writes over a single req/ack register-write port, in that order.
- Reports done or err with a one-cycle pulse.

---
 rtl/rtc_time_writer_if.sv | 24 ++
 rtl/rtc_time_writer.sv | 102 ++++++++++
 tb/tb_rtc_time_writer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_time_writer_if.sv
// rtc_time_writer_if: edit-stage time inputs plus the req/ack RTC register-write port.
interface rtc_time_writer_if;
    logic [7:0] HC;
    logic [7:0] MC;
    logic [7:0] SC;
    logic       AmPm;
    logic       format;
    logic       commit;
    logic       wr_ack;
    logic [7:0] bus_addr;
    logic [7:0] bus_data;
    logic       wr_req;
    logic       busy;
    logic       done;
    logic       err;
    modport master (
        input  HC, MC, SC, AmPm, format, commit, wr_ack,
        output bus_addr, bus_data, wr_req, busy, done, err
    );
    modport slave (
        output HC, MC, SC, AmPm, format, commit, wr_ack,
        input  bus_addr, bus_data, wr_req, busy, done, err
    );
endinterface

// File: rtl/rtc_time_writer.sv
// rtc_time_writer: validates committed BCD time and writes sec/min/hour into the RTC over req/ack.
// Optional RTC_CLOCK_HALT_EN: halts the oscillator during the update and restarts it with a 4th write.
module rtc_time_writer #(
    parameter logic [7:0]  ADDR_SEC  = 8'h21,
    parameter logic [7:0]  ADDR_MIN  = 8'h22,
    parameter logic [7:0]  ADDR_HOUR = 8'h23,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic               clk,
    input logic               reset,
    rtc_time_writer_if.master bus
);
    typedef enum logic [2:0] {IDLE, CHECK, SETUP, REQ, GAP, DONE, ERR} state_t;
`ifdef RTC_CLOCK_HALT_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
    localparam logic       HALT_BIT = 1'b1;
    localparam logic       RECOVER  = 1'b1;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
    localparam logic       HALT_BIT = 1'b0;
    localparam logic       RECOVER  = 1'b0;
`endif
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    state_t     r_state, w_next;
    logic [7:0] r_hc, r_mc, r_sc, r_addr, r_data, r_cnt;
    logic       r_ampm, r_fmt, r_rec;
    logic [1:0] r_idx, w_idx;
    logic [7:0] w_hour, w_addr, w_data;
    logic       w_valid, w_timeout, w_last;
    assign w_valid = r_hc[3:0] <= 4'd9 && r_hc[7:4] <= 4'd9 &&
                     r_mc[3:0] <= 4'd9 && r_mc[7:4] <= 4'd5 &&
                     r_sc[3:0] <= 4'd9 && r_sc[7:4] <= 4'd5 &&
                     (r_fmt ? (r_hc >= 8'h01 && r_hc <= 8'h12) : r_hc <= 8'h23);
    assign w_hour    = r_fmt ? {2'b01, r_ampm, r_hc[4:0]} : {2'b00, r_hc[5:0]};
    assign w_addr    = (w_idx == 2'd1) ? ADDR_MIN : (w_idx == 2'd2) ? ADDR_HOUR : ADDR_SEC;
    assign w_data    = (w_idx == 2'd0) ? {HALT_BIT, r_sc[6:0]} :
                       (w_idx == 2'd1) ? {1'b0, r_mc[6:0]} :
                       (w_idx == 2'd2) ? w_hour : {1'b0, r_sc[6:0]};
    assign w_timeout = r_cnt == CNT_LAST;
    // A recovery write is always the final one
    assign w_last    = r_rec || r_idx == LAST_IDX;
    always_comb begin
        w_next = r_state;
        w_idx  = r_idx;
        case (r_state)
            IDLE: if (bus.commit) begin
                w_next = CHECK;
                w_idx  = 2'd0;
            end
            CHECK: w_next = w_valid ? SETUP : ERR;
            SETUP: w_next = REQ;
            REQ: if (bus.wr_ack) begin
                w_next = w_last ? (r_rec ? ERR : DONE) : GAP;
                w_idx  = r_idx + 2'd1;
            end else if (w_timeout) begin
                w_next = (RECOVER && !r_rec) ? SETUP : ERR;
                w_idx  = 2'd3;
            end
            GAP: w_next = SETUP;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_hc    <= 8'd0;
            r_mc    <= 8'd0;
            r_sc    <= 8'd0;
            r_ampm  <= 1'b0;
            r_fmt   <= 1'b0;
            r_rec   <= 1'b0;
            r_idx   <= 2'd0;
            r_cnt   <= 8'd0;
            r_addr  <= 8'd0;
            r_data  <= 8'd0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx;
            r_cnt   <= (r_state == REQ) ? r_cnt + 8'd1 : 8'd0;
            if (r_state == IDLE && bus.commit) begin
                r_hc   <= bus.HC;
                r_mc   <= bus.MC;
                r_sc   <= bus.SC;
                r_ampm <= bus.AmPm;
                r_fmt  <= bus.format;
                r_rec  <= 1'b0;
            end
            if (r_state == REQ && !bus.wr_ack && w_timeout)
                r_rec <= 1'b1;
            if (w_next == SETUP) begin
                r_addr <= w_addr;
                r_data <= w_data;
            end
        end
    end
    assign bus.wr_req   = r_state == REQ;
    assign bus.busy     = r_state inside {CHECK, SETUP, REQ, GAP};
    assign bus.done     = r_state == DONE;
    assign bus.err      = r_state == ERR;
    assign bus.bus_addr = r_addr;
    assign bus.bus_data = r_data;
endmodule

// File: tb/tb_rtc_time_writer.sv
// tb_rtc_time_writer: directed checks of validation, encoding, write order, timing, timeout and reset.
module tb_rtc_time_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    rtc_time_writer_if bus();
    rtc_time_writer dut (.clk(clk), .reset(reset), .bus(bus));
`ifdef RTC_CLOCK_HALT_EN
    localparam int NW = 4;
`else
    localparam int NW = 3;
`endif
    int tests_run = 0, fails = 0;
    int ack_delay = 0, rc = 0, n_wr = 0, req_cyc = 0, n_done = 0, n_err = 0, n_both = 0, n_unstable = 0;
    int k_done, k_err;
    logic b_end, ack;
    logic clr = 1'b0, prev_req = 1'b0;
    logic [7:0] pa = 8'd0, pd = 8'd0;
    logic [7:0] log_a [8];
    logic [7:0] log_d [8];
    // RTC model: acks ack_delay cycles after wr_req rises and logs each accepted write
    always @(negedge clk) begin
        if (clr) begin
            n_wr = 0; req_cyc = 0; n_done = 0; n_err = 0; n_both = 0; n_unstable = 0;
        end
        if (bus.wr_req) req_cyc++;
        if (bus.done) n_done++;
        if (bus.err) n_err++;
        if (bus.done && bus.err) n_both++;
        if (bus.wr_req && prev_req && (bus.bus_addr !== pa || bus.bus_data !== pd)) n_unstable++;
        prev_req = bus.wr_req; pa = bus.bus_addr; pd = bus.bus_data;
        if (bus.wr_req) begin
            ack = (rc == ack_delay);
            if (ack && n_wr < 8) begin
                log_a[n_wr] = bus.bus_addr; log_d[n_wr] = bus.bus_data; n_wr++;
            end
            rc++;
        end else begin
            ack = 1'b0; rc = 0;
        end
        bus.wr_ack = ack;
    end
    task automatic clear();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask
    task automatic go(input logic [7:0] h, m, s, input logic ap, fm, input int budget);
        @(negedge clk);
        bus.HC = h; bus.MC = m; bus.SC = s; bus.AmPm = ap; bus.format = fm; bus.commit = 1'b1;
        k_done = -1; k_err = -1; b_end = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            bus.commit = 1'b0;
            if (bus.done || bus.err) begin
                if (bus.done) k_done = k;
                if (bus.err) k_err = k;
                b_end = bus.busy;
                break;
            end
        end
        repeat (2) @(negedge clk);
        #1;
    endtask
    task automatic test_reset();
        bus.HC = 8'd0; bus.MC = 8'd0; bus.SC = 8'd0; bus.AmPm = 1'b0; bus.format = 1'b0; bus.commit = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus.bus_addr, bus.bus_data} !== 16'h0000) begin
            fails++; $display("FAIL reset_bus got %h/%h exp 00/00", bus.bus_addr, bus.bus_data);
        end
        tests_run++;
        if ({bus.wr_req, bus.busy, bus.done, bus.err} !== 4'b0000) begin
            fails++; $display("FAIL reset_ctrl got req/busy/done/err=%b exp 0000", {bus.wr_req, bus.busy, bus.done, bus.err});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask
    task automatic test_invalid();
        logic [7:0] th [6] = '{8'h24, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0A};
        logic [7:0] tm [6] = '{8'h00, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] ts [6] = '{8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00};
        logic       tf [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ack_delay = 0;
        for (int i = 0; i < 6; i++) begin
            clear();
            go(th[i], tm[i], ts[i], 1'b0, tf[i], 10);
            tests_run++;
            if (k_err !== 2 || k_done !== -1) begin
                fails++; $display("FAIL invalid%0d_err_time got err@%0d done@%0d exp err@2 done@-1", i, k_err, k_done);
            end
            tests_run++;
            if (req_cyc !== 0 || n_err !== 1 || b_end !== 1'b0) begin
                fails++; $display("FAIL invalid%0d_quiet got req_cyc=%0d errs=%0d busy=%b exp 0/1/0", i, req_cyc, n_err, b_end);
            end
            tests_run++;
            if ({bus.bus_addr, bus.bus_data} !== 16'h0000) begin
                fails++; $display("FAIL invalid%0d_bus got %h/%h exp 00/00", i, bus.bus_addr, bus.bus_data);
            end
        end
    endtask
    task automatic test_24h();
        logic [7:0] ea [4] = '{8'h21, 8'h22, 8'h23, 8'h21};
`ifdef RTC_CLOCK_HALT_EN
        logic [7:0] ed [4] = '{8'hD8, 8'h59, 8'h23, 8'h58};
`else
        logic [7:0] ed [4] = '{8'h58, 8'h59, 8'h23, 8'h00};
`endif
        ack_delay = 2;
        clear();
        go(8'h23, 8'h59, 8'h58, 1'b0, 1'b0, 80);
        tests_run++;
        if (n_wr !== NW) begin
            fails++; $display("FAIL 24h_count got %0d writes exp %0d", n_wr, NW);
        end
        for (int i = 0; i < NW; i++) begin
            tests_run++;
            if (log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
                fails++; $display("FAIL 24h_write%0d got (%h,%h) exp (%h,%h)", i, log_a[i], log_d[i], ea[i], ed[i]);
            end
        end
        tests_run++;
        if (n_done !== 1 || n_err !== 0 || n_both !== 0 || n_unstable !== 0) begin
            fails++; $display("FAIL 24h_status got done=%0d err=%0d both=%0d unstable=%0d exp 1/0/0/0", n_done, n_err, n_both, n_unstable);
        end
    endtask
    task automatic test_12h();
        ack_delay = 0;
        clear();
        go(8'h12, 8'h05, 8'h00, 1'b1, 1'b1, 40);
        tests_run++;
        if (log_a[2] !== 8'h23 || log_d[2] !== 8'h72) begin
            fails++; $display("FAIL 12h_hour got (%h,%h) exp (23,72)", log_a[2], log_d[2]);
        end
        tests_run++;
        if (k_done !== 7 + 3 * (NW - 2) || k_err !== -1 || b_end !== 1'b0) begin
            fails++; $display("FAIL 12h_done_time got done@%0d err@%0d busy=%b exp done@%0d", k_done, k_err, b_end, 7 + 3 * (NW - 2));
        end
    endtask
    task automatic test_timeout();
        ack_delay = 1000;
        clear();
        go(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 700);
        tests_run++;
        if (k_err <= 0 || k_done !== -1 || b_end !== 1'b0 || n_err !== 1) begin
            fails++; $display("FAIL timeout_err got err@%0d done@%0d busy=%b errs=%0d exp one err, busy 0", k_err, k_done, b_end, n_err);
        end
        tests_run++;
        if (req_cyc !== 255 * (NW - 2) || bus.wr_req !== 1'b0) begin
            fails++; $display("FAIL timeout_req_cycles got %0d req=%b exp %0d req=0", req_cyc, bus.wr_req, 255 * (NW - 2));
        end
        tests_run++;
        if (bus.bus_addr !== 8'h21 || bus.bus_data !== 8'h03) begin
            fails++; $display("FAIL timeout_bus got (%h,%h) exp (21,03)", bus.bus_addr, bus.bus_data);
        end
    endtask
    task automatic test_back_to_back();
        logic [7:0] first_d = (NW == 4) ? 8'hB0 : 8'h30;
        logic [7:0] last_d  = (NW == 4) ? 8'h30 : 8'h10;
        ack_delay = 1;
        clear();
        @(negedge clk);
        bus.HC = 8'h10; bus.MC = 8'h20; bus.SC = 8'h30; bus.format = 1'b0; bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
        repeat (2) @(negedge clk);
        bus.HC = 8'h01; bus.MC = 8'h01; bus.SC = 8'h01; bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        tests_run++;
        if (n_done !== 1 || n_err !== 0 || n_wr !== NW) begin
            fails++; $display("FAIL b2b_count got done=%0d err=%0d writes=%0d exp 1/0/%0d", n_done, n_err, n_wr, NW);
        end
        tests_run++;
        if (log_d[0] !== first_d || log_d[NW-1] !== last_d || log_d[2] !== 8'h10) begin
            fails++; $display("FAIL b2b_data got first=%h last=%h hour=%h exp %h/%h/10", log_d[0], log_d[NW-1], log_d[2], first_d, last_d);
        end
    endtask
    task automatic test_reset_mid();
        logic found = 1'b0;
        ack_delay = 3;
        clear();
        @(negedge clk);
        bus.HC = 8'h01; bus.MC = 8'h02; bus.SC = 8'h03; bus.format = 1'b0; bus.commit = 1'b1;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            bus.commit = 1'b0;
            found = bus.wr_req && bus.bus_addr == 8'h22;
        end
        tests_run++;
        if (!found) begin
            fails++; $display("FAIL reset_mid_reach got no minutes request exp one within 30 cycles");
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (bus.wr_req !== 1'b0 || bus.busy !== 1'b0 || bus.bus_addr !== 8'h00) begin
            fails++; $display("FAIL reset_mid_async got req=%b busy=%b addr=%h exp 0/0/00", bus.wr_req, bus.busy, bus.bus_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask
    initial begin
        test_reset();
        test_invalid();
        test_24h();
        test_12h();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
